// File: rtl/rover_pose_tracker_pkg.sv
// ============================================================================
// rover_pose_tracker_pkg : shared widths, heading encoding, Q8 trig table
// Revision: 1.0
// ============================================================================
`default_nettype none

package rover_pose_tracker_pkg;

    localparam int COORD_W  = 12;
    localparam int ORIENT_W = 5;
    localparam int TRIG_W   = 10;
    localparam int POS_W    = 15;
    localparam int N_THRESH = 6;

    localparam logic [ORIENT_W-1:0] D90  = 5'd6;
    localparam logic [ORIENT_W-1:0] D180 = 5'd12;
    localparam logic [ORIENT_W-1:0] D360 = 5'd24;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_MULT    = 3'd2,
        ST_POS     = 3'd3,
        ST_HEADING = 3'd4,
        ST_PENDING = 3'd5
    } state_e;

    // cos(15k deg) in Q8; sin(15k deg) is the same table read at 6-k
    function automatic logic [8:0] trig_q8(input logic [2:0] k);
        case (k)
            3'd0:    trig_q8 = 9'd256;
            3'd1:    trig_q8 = 9'd247;
            3'd2:    trig_q8 = 9'd222;
            3'd3:    trig_q8 = 9'd181;
            3'd4:    trig_q8 = 9'd128;
            3'd5:    trig_q8 = 9'd66;
            default: trig_q8 = 9'd0;
        endcase
    endfunction

    function automatic logic [8:0] heading_thresh(input int idx);
        case (idx)
            0:       heading_thresh = 9'd8;
            1:       heading_thresh = 9'd27;
            2:       heading_thresh = 9'd49;
            3:       heading_thresh = 9'd83;
            4:       heading_thresh = 9'd155;
            default: heading_thresh = 9'd486;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/trig_lut_15deg.sv
// ============================================================================
// trig_lut_15deg : registered signed Q8 cos/sin for a 15-degree angle index
// Revision: 1.0
// ============================================================================
`default_nettype none

module trig_lut_15deg
    import rover_pose_tracker_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [ORIENT_W-1:0]      angle_i,
    output logic signed [TRIG_W-1:0] cos_o,
    output logic signed [TRIG_W-1:0] sin_o
);

    logic [ORIENT_W-1:0]      w_ang;
    logic [1:0]               w_quad;
    logic [2:0]               w_k;
    logic [8:0]               w_mag_k;
    logic [8:0]               w_mag_c;
    logic signed [TRIG_W-1:0] w_pk;
    logic signed [TRIG_W-1:0] w_pc;
    logic signed [TRIG_W-1:0] cos_d;
    logic signed [TRIG_W-1:0] sin_d;
    logic signed [TRIG_W-1:0] cos_q;
    logic signed [TRIG_W-1:0] sin_q;

    always_comb begin
        w_ang = (angle_i >= D360) ? '0 : angle_i;
        if (w_ang < D90) begin
            w_quad = 2'd0;
            w_k    = 3'(w_ang);
        end else if (w_ang < D180) begin
            w_quad = 2'd1;
            w_k    = 3'(w_ang - D90);
        end else if (w_ang < (D180 + D90)) begin
            w_quad = 2'd2;
            w_k    = 3'(w_ang - D180);
        end else begin
            w_quad = 2'd3;
            w_k    = 3'(w_ang - D180 - D90);
        end

        w_mag_k = trig_q8(w_k);
        w_mag_c = trig_q8(3'd6 - w_k);
        w_pk    = $signed({1'b0, w_mag_k});
        w_pc    = $signed({1'b0, w_mag_c});

        // Rotating by 90 degrees swaps cos/sin magnitudes and flips one sign
        case (w_quad)
            2'd0: begin cos_d =  w_pk; sin_d =  w_pc; end
            2'd1: begin cos_d = -w_pc; sin_d =  w_pk; end
            2'd2: begin cos_d = -w_pk; sin_d = -w_pc; end
            default: begin cos_d = w_pc; sin_d = -w_pk; end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cos_q <= '0;
            sin_q <= '0;
        end else begin
            cos_q <= cos_d;
            sin_q <= sin_d;
        end
    end

    assign cos_o = cos_q;
    assign sin_o = sin_q;

endmodule

`default_nettype wire

// File: rtl/rover_pose_tracker.sv
// ============================================================================
// rover_pose_tracker : polar measurement -> screen pose, committed at vsync
// Revision: 1.0
// ============================================================================
`default_nettype none

module rover_pose_tracker
    import rover_pose_tracker_pkg::*;
#(
    parameter int ORIGIN_X = 512,
    parameter int ORIGIN_Y = 384,
    parameter int X_MAX    = 1023,
    parameter int Y_MAX    = 767,
    parameter int MIN_MOVE = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      meas_valid,
    input  logic [11:0]               meas_distance,
    input  logic [4:0]                meas_angle,
    input  logic                      vsync_start,
    output logic                      meas_ready,
    output logic signed [COORD_W-1:0] center_x,
    output logic signed [COORD_W-1:0] center_y,
    output logic [ORIENT_W-1:0]       orientation,
    output logic                      pose_updated
);

    localparam logic signed [POS_W-1:0]   OX_P   = POS_W'(ORIGIN_X);
    localparam logic signed [POS_W-1:0]   OY_P   = POS_W'(ORIGIN_Y);
    localparam logic signed [POS_W-1:0]   XMAX_P = POS_W'(X_MAX);
    localparam logic signed [POS_W-1:0]   YMAX_P = POS_W'(Y_MAX);
    localparam logic [POS_W-1:0]          MINM_P = POS_W'(MIN_MOVE);
    localparam logic signed [COORD_W-1:0] OX_C   = COORD_W'(ORIGIN_X);
    localparam logic signed [COORD_W-1:0] OY_C   = COORD_W'(ORIGIN_Y);

    state_e state_q, state_d;

    logic                      w_accept;
    logic                      w_commit;

    logic [11:0]               dist_q;
    logic [ORIENT_W-1:0]       angle_q;
    logic signed [TRIG_W-1:0]  w_cos;
    logic signed [TRIG_W-1:0]  w_sin;
    logic [8:0]                w_cos_abs;
    logic [8:0]                w_sin_abs;
    logic [20:0]               prod_x_q;
    logic [20:0]               prod_y_q;
    logic [12:0]               w_mag_x;
    logic [12:0]               w_mag_y;
    logic signed [POS_W-1:0]   w_x_raw;
    logic signed [POS_W-1:0]   w_y_raw;
    logic signed [POS_W-1:0]   w_x_clamp;
    logic signed [POS_W-1:0]   w_y_clamp;
    logic signed [POS_W-1:0]   x_q;
    logic signed [POS_W-1:0]   y_q;
    logic signed [POS_W-1:0]   dx_q;
    logic signed [POS_W-1:0]   dy_q;
    logic signed [POS_W-1:0]   prev_x_q;
    logic signed [POS_W-1:0]   prev_y_q;
    logic [POS_W-1:0]          w_adx;
    logic [POS_W-1:0]          w_ady;
    logic [24:0]               w_lhs;
    logic [2:0]                w_s;
    logic [ORIENT_W-1:0]       w_s5;
    logic [ORIENT_W-1:0]       w_orient_map;
    logic [ORIENT_W-1:0]       w_new_orient;
    logic [ORIENT_W-1:0]       new_orient_q;
    logic                      first_q;
    logic signed [COORD_W-1:0] center_x_q;
    logic signed [COORD_W-1:0] center_y_q;
    logic [ORIENT_W-1:0]       orient_q;
    logic                      pose_updated_q;

    trig_lut_15deg u_trig (
        .clock   (clock),
        .reset_n (reset_n),
        .angle_i (angle_q),
        .cos_o   (w_cos),
        .sin_o   (w_sin)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (meas_valid) state_d = ST_LOOKUP;
            ST_LOOKUP:  state_d = ST_MULT;
            ST_MULT:    state_d = ST_POS;
            ST_POS:     state_d = ST_HEADING;
            ST_HEADING: state_d = ST_PENDING;
            ST_PENDING: if (vsync_start) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        meas_ready = (state_q == ST_IDLE);
        w_accept   = meas_ready && meas_valid;
        w_commit   = (state_q == ST_PENDING) && vsync_start;
    end

    always_comb begin
        w_cos_abs = w_cos[TRIG_W-1] ? 9'(-w_cos) : 9'(w_cos);
        w_sin_abs = w_sin[TRIG_W-1] ? 9'(-w_sin) : 9'(w_sin);

        w_mag_x = 13'(prod_x_q >> 8);
        w_mag_y = 13'(prod_y_q >> 8);
        // The LUT output still holds this measurement's signs during POS
        w_x_raw = w_cos[TRIG_W-1] ? OX_P - $signed({2'b00, w_mag_x})
                                  : OX_P + $signed({2'b00, w_mag_x});
        w_y_raw = w_sin[TRIG_W-1] ? OY_P - $signed({2'b00, w_mag_y})
                                  : OY_P + $signed({2'b00, w_mag_y});
        if (w_x_raw < 0)           w_x_clamp = '0;
        else if (w_x_raw > XMAX_P) w_x_clamp = XMAX_P;
        else                       w_x_clamp = w_x_raw;
        if (w_y_raw < 0)           w_y_clamp = '0;
        else if (w_y_raw > YMAX_P) w_y_clamp = YMAX_P;
        else                       w_y_clamp = w_y_raw;
    end

    always_comb begin
        w_adx = dx_q[POS_W-1] ? POS_W'(-dx_q) : POS_W'(dx_q);
        w_ady = dy_q[POS_W-1] ? POS_W'(-dy_q) : POS_W'(dy_q);
        w_lhs = 25'(w_ady) << 6;
        w_s   = 3'd0;
        for (int i = 0; i < N_THRESH; i++) begin
            if (w_lhs > 25'(w_adx) * 25'(heading_thresh(i))) w_s = w_s + 3'd1;
        end
        w_s5 = {2'b00, w_s};
        case ({dx_q[POS_W-1], dy_q[POS_W-1]})
            2'b00:   w_orient_map = w_s5;
            2'b10:   w_orient_map = D180 - w_s5;
            2'b11:   w_orient_map = D180 + w_s5;
            default: w_orient_map = (w_s5 == '0) ? '0 : D360 - w_s5;
        endcase
        if (first_q || ((w_adx < MINM_P) && (w_ady < MINM_P)))
            w_new_orient = orient_q;
        else
            w_new_orient = w_orient_map;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dist_q         <= '0;
            angle_q        <= '0;
            prod_x_q       <= '0;
            prod_y_q       <= '0;
            x_q            <= '0;
            y_q            <= '0;
            dx_q           <= '0;
            dy_q           <= '0;
            new_orient_q   <= '0;
            first_q        <= 1'b1;
            prev_x_q       <= OX_P;
            prev_y_q       <= OY_P;
            center_x_q     <= OX_C;
            center_y_q     <= OY_C;
            orient_q       <= '0;
            pose_updated_q <= 1'b0;
        end else begin
            pose_updated_q <= w_commit;
            if (w_accept) begin
                dist_q  <= meas_distance;
                angle_q <= meas_angle;
            end
            if (state_q == ST_MULT) begin
                prod_x_q <= 21'(dist_q) * 21'(w_cos_abs);
                prod_y_q <= 21'(dist_q) * 21'(w_sin_abs);
            end
            if (state_q == ST_POS) begin
                x_q  <= w_x_clamp;
                y_q  <= w_y_clamp;
                dx_q <= w_x_clamp - prev_x_q;
                dy_q <= w_y_clamp - prev_y_q;
            end
            if (state_q == ST_HEADING) begin
                new_orient_q <= w_new_orient;
                first_q      <= 1'b0;
            end
            if (w_commit) begin
                center_x_q <= x_q[COORD_W-1:0];
                center_y_q <= y_q[COORD_W-1:0];
                orient_q   <= new_orient_q;
                prev_x_q   <= x_q;
                prev_y_q   <= y_q;
            end
        end
    end

    assign center_x     = center_x_q;
    assign center_y     = center_y_q;
    assign orientation  = orient_q;
    assign pose_updated = pose_updated_q;

endmodule

`default_nettype wire

// File: doc/rover_pose_tracker.md
Name: rover_pose_tracker

Overview:
- Upstream feeder of the screen triangle sprite renderer.
- Converts each polar rover measurement (distance, 15° angle index) into screen coordinates (center_x, center_y).
- Derives a heading orientation in 15° steps from the displacement since the previous accepted position.
- Commits the new pose only at a frame boundary, so the sprite never tears mid-frame.

Parameters:
ORIGIN_X, 512, screen x of the measurement origin
ORIGIN_Y, 384, screen y of the measurement origin
X_MAX, 1023, largest legal center_x (clamp bound)
Y_MAX, 767, largest legal center_y (clamp bound)
MIN_MOVE, 2, |dx| and |dy| both below this hold the previous orientation

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous, active-low reset
meas_valid  in  1  measurement offered
meas_distance  in  12  unsigned distance, pixels
meas_angle  in  5  angle index 0..23, 15° steps; values >23 are treated as 0
vsync_start  in  1  one-cycle pulse at frame start
meas_ready  out  1  high only in IDLE
center_x  out  12 signed  committed sprite x
center_y  out  12 signed  committed sprite y
orientation  out  5  committed heading 0..23, same encoding as the sprite renderer
pose_updated  out  1  one-cycle pulse on the cycle the outputs change

Behaviour:
- Reset (reset_n low at a clock edge):
  - center_x=ORIGIN_X, center_y=ORIGIN_Y, orientation=0, pose_updated=0.
  - prev position = origin; first_flag=1; state=IDLE, so meas_ready=1 on the next cycle.
  - Reset in any state aborts the calculation in flight.
- FSM states: IDLE -> LOOKUP -> MULT -> POS -> HEADING -> PENDING -> IDLE.
  - IDLE: on meas_valid&&meas_ready, latch distance and angle, go to LOOKUP. No accept happens in any other state; offers are ignored, not queued.
  - LOOKUP: registered sin/cos fetch.
    - Q8 magnitudes for k=0..6: cos = 256,247,222,181,128,66,0; sin = table(6-k).
    - Quadrant q = angle/6, k = angle mod 6 (k=6 cannot occur).
    - Signs are those of the angle: Q1 (+,+), Q2 (-,+), Q3 (-,-), Q4 (+,-).
  - MULT: prod_x = distance*cos and prod_y = distance*sin, 21-bit unsigned; arithmetic >>8 gives 13-bit magnitudes.
  - POS:
    - x = ORIGIN_X ± mag_x, y = ORIGIN_Y ± mag_y, in 15-bit signed.
    - Clamp to [0,X_MAX] and [0,Y_MAX].
    - dx = x-prev_x, dy = y-prev_y.
  - HEADING:
    - If first_flag, or |dx|<MIN_MOVE and |dy|<MIN_MOVE: new_orient = orientation (held).
    - Otherwise s = count of t in {8,27,49,83,155,486} with |dy|*64 > |dx|*t (s=0..6).
    - Quadrant map:
      - dx>=0, dy>=0 -> s
      - dx<0, dy>=0 -> 12-s
      - dx<0, dy<0 -> 12+s
      - dx>=0, dy<0 -> (24-s) mod 24
    - Result is always 0..23.
    - Then clear first_flag and go to PENDING.
  - PENDING: on the first vsync_start sampled high in this state, at that edge:
    - center_x/center_y <= clamped x/y; orientation <= new_orient.
    - prev <= x/y; pose_updated <= 1 for one cycle; state -> IDLE.
  - vsync_start pulses in any other state are ignored.
- Latency: accept at edge N; PENDING entered at edge N+4; commit at the first vsync edge at or after N+5.
- Outputs change only at commit; they are otherwise stable for the whole frame.
- prev position updates only on commit, including when orientation is held.

Decomposition:
- Shared package: sprite coordinate width (12), orientation encoding constants (D90=6, D180=12, D360=24), the Q8 trig table, and the heading threshold list {8,27,49,83,155,486}.
- One sub-module: trig_lut_15deg.
  - Input: angle index. Outputs: registered signed Q8 cos/sin.
  - Used by the LOOKUP state.

Test Plan:
- Reset, then d=100 angle 0, vsync -> center=(612,384), orientation 0 (first sample held), pose_updated one pulse.
- Then d=100 angle 6, vsync -> center=(512,484); dx=-100, dy=+100 gives s=3 -> orientation 9.
- d=50 angle 0 with no vsync for 20 cycles -> outputs unchanged, meas_ready=0, second meas_valid ignored; the next vsync commits (562,384).
- Displacement dx=+100, dy=-1 -> orientation 0 (Q4 wrap, 24 mod 24); dx=1, dy=1 -> previous orientation held.
- d=4000 angle 0 -> center_x clamped to 1023; d=4000 angle 18 -> center_y clamped to 0.
- reset_n low during PENDING -> outputs return to (512,384), orientation 0, no pose_updated, meas_ready=1 on the next cycle.
